// File: rtl/pong_pkg.sv
// Shared constants for the pong drawing path: VGA adapter geometry, bus widths
// and the palette used by the sprite controllers and datapaths.
package pong_pkg;

   localparam int VGA_W = 160;
   localparam int VGA_H = 120;
   localparam int X_W   = 8;
   localparam int Y_W   = 7;

   localparam int DEFAULT_COLOUR_W = 3;

   localparam logic [DEFAULT_COLOUR_W-1:0] COL_BLACK = 3'b000;
   localparam logic [DEFAULT_COLOUR_W-1:0] COL_BLUE  = 3'b001;
   localparam logic [DEFAULT_COLOUR_W-1:0] COL_GREEN = 3'b010;
   localparam logic [DEFAULT_COLOUR_W-1:0] COL_RED   = 3'b100;
   localparam logic [DEFAULT_COLOUR_W-1:0] COL_WHITE = 3'b111;

   localparam logic [DEFAULT_COLOUR_W-1:0] DEFAULT_BG_COLOUR = COL_BLACK;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter that holds at zero while disabled; 'last' flags the
// final count of each lap so callers can branch on it in the same cycle.
module mod_counter #(
   parameter int MODULUS = 4,
   parameter int W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         last
);

   localparam logic [W-1:0] LAST_COUNT = W'(MODULUS - 1);

   always_ff @(posedge clock) begin
      if (!resetn || !en)
         count <= '0;
      else if (count == LAST_COUNT)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign last = en & (count == LAST_COUNT);

endmodule

// File: rtl/pong_draw_datapath.sv
// Sprite sweep and frame-wait datapath for one pong object: latches an origin,
// walks a SPRITE_W x SPRITE_H box into the VGA write port, and times the frame wait.
module pong_draw_datapath
   import pong_pkg::*;
#(
   parameter int                    SPRITE_W    = 4,
   parameter int                    SPRITE_H    = 4,
   parameter int                    WAIT_CYCLES = 833333,
   parameter int                    COLOUR_W    = DEFAULT_COLOUR_W,
   parameter logic [COLOUR_W-1:0]   BG_COLOUR   = COLOUR_W'(DEFAULT_BG_COLOUR)
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                ld_x_out,
   input  logic                ld_y_out,
   input  logic                enable_posCounter,
   input  logic                enable_waitCounter,
   input  logic                sel_col,
   input  logic                plot,
   input  logic [X_W-1:0]      x_in,
   input  logic [Y_W-1:0]      y_in,
   input  logic [COLOUR_W-1:0] colour_in,
   output logic                done,
   output logic                waited,
   output logic [X_W-1:0]      x_vga,
   output logic [Y_W-1:0]      y_vga,
   output logic [COLOUR_W-1:0] colour_vga,
   output logic                writeEn
);

   localparam int PIX_N  = SPRITE_W * SPRITE_H;
   localparam int PIX_W  = (PIX_N > 1) ? $clog2(PIX_N) : 1;
   localparam int WAIT_W = $clog2(WAIT_CYCLES);

   logic [X_W-1:0]      x_base;
   logic [Y_W-1:0]      y_base;
   logic [COLOUR_W-1:0] colour_reg;
   logic [PIX_W-1:0]    pix_idx;
   logic [PIX_W-1:0]    col;
   logic [PIX_W-1:0]    row;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [X_W:0]        x_sum;
   logic [Y_W:0]        y_sum;
   logic                on_screen;

   // One flat pixel index; col/row fall out of it so both wrap together on the last pixel.
   mod_counter #(.MODULUS(PIX_N), .W(PIX_W)) u_pix_cnt (
      .clock  (clock),
      .resetn (resetn),
      .en     (enable_posCounter),
      .count  (pix_idx),
      .last   (done)
   );

   mod_counter #(.MODULUS(WAIT_CYCLES), .W(WAIT_W)) u_wait_cnt (
      .clock  (clock),
      .resetn (resetn),
      .en     (enable_waitCounter),
      .count  (wait_cnt),
      .last   (waited)
   );

   assign col = PIX_W'(int'(pix_idx) % SPRITE_W);
   assign row = PIX_W'(int'(pix_idx) / SPRITE_W);

   // Sums keep one carry bit so off-screen pixels are clipped rather than wrapped.
   assign x_sum     = {1'b0, x_base} + (X_W+1)'(col);
   assign y_sum     = {1'b0, y_base} + (Y_W+1)'(row);
   assign on_screen = (x_sum <= (X_W+1)'(VGA_W - 1)) && (y_sum <= (Y_W+1)'(VGA_H - 1));

   always_ff @(posedge clock) begin
      if (!resetn) begin
         x_base     <= '0;
         y_base     <= '0;
         colour_reg <= '0;
         x_vga      <= '0;
         y_vga      <= '0;
         colour_vga <= '0;
         writeEn    <= 1'b0;
      end else begin
         if (ld_x_out) begin
            x_base     <= x_in;
            colour_reg <= colour_in;
         end
         if (ld_y_out)
            y_base <= y_in;
         x_vga      <= x_sum[X_W-1:0];
         y_vga      <= y_sum[Y_W-1:0];
         colour_vga <= sel_col ? BG_COLOUR : colour_reg;
         writeEn    <= plot & enable_posCounter & on_screen;
      end
   end

   wait_cnt_in_range: assert property (@(posedge clock) disable iff (!resetn)
      wait_cnt <= WAIT_W'(WAIT_CYCLES - 1));

endmodule

// File: tb/tb_pong_draw_datapath.sv
// Directed bench for pong_draw_datapath with a 4x4 sprite and a 5-cycle wait.
module tb_pong_draw_datapath;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       ld_x_out = 1'b0;
   logic       ld_y_out = 1'b0;
   logic       enable_posCounter = 1'b0;
   logic       enable_waitCounter = 1'b0;
   logic       sel_col = 1'b0;
   logic       plot = 1'b0;
   logic [7:0] x_in = '0;
   logic [6:0] y_in = '0;
   logic [2:0] colour_in = '0;
   logic       done;
   logic       waited;
   logic [7:0] x_vga;
   logic [6:0] y_vga;
   logic [2:0] colour_vga;
   logic       writeEn;

   int checks = 0;
   int errors = 0;

   pong_draw_datapath #(
      .SPRITE_W(4), .SPRITE_H(4), .WAIT_CYCLES(5), .COLOUR_W(3), .BG_COLOUR(3'b000)
   ) dut (
      .clock              (clock),
      .resetn             (resetn),
      .ld_x_out           (ld_x_out),
      .ld_y_out           (ld_y_out),
      .enable_posCounter  (enable_posCounter),
      .enable_waitCounter (enable_waitCounter),
      .sel_col            (sel_col),
      .plot               (plot),
      .x_in               (x_in),
      .y_in               (y_in),
      .colour_in          (colour_in),
      .done               (done),
      .waited             (waited),
      .x_vga              (x_vga),
      .y_vga              (y_vga),
      .colour_vga         (colour_vga),
      .writeEn            (writeEn)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      x_in = x; y_in = y; colour_in = c;
      ld_x_out = 1'b1; ld_y_out = 1'b1;
      tick();
      ld_x_out = 1'b0; ld_y_out = 1'b0;
   endtask

   // Full 16-pixel sweep; optionally runs the wait counter alongside.
   task automatic sweep(input string name, input logic [7:0] xo, input logic [6:0] yo,
                        input logic [2:0] exp_c, input logic sel, input logic with_wait,
                        input int exp_writes);
      int   writes;
      int   ex;
      int   ey;
      logic exp_we;
      writes = 0;
      sel_col = sel; plot = 1'b1; enable_posCounter = 1'b1; enable_waitCounter = with_wait;
      for (int i = 0; i < 16; i++) begin
         #1;
         checks++;
         if (done !== 1'(i == 15))
            begin errors++; $display("FAIL %s done px%0d got %b want %b", name, i, done, (i == 15)); end
         if (with_wait) begin
            checks++;
            if (waited !== 1'((i % 5) == 4))
               begin errors++; $display("FAIL %s waited cyc%0d got %b want %b", name, i, waited, ((i % 5) == 4)); end
         end
         tick();
         ex = int'(xo) + (i % 4);
         ey = int'(yo) + (i / 4);
         exp_we = (ex <= 159) && (ey <= 119);
         checks++;
         if (writeEn !== exp_we)
            begin errors++; $display("FAIL %s writeEn px%0d got %b want %b", name, i, writeEn, exp_we); end
         checks++;
         if (x_vga !== 8'(ex))
            begin errors++; $display("FAIL %s x_vga px%0d got %0d want %0d", name, i, x_vga, 8'(ex)); end
         checks++;
         if (y_vga !== 7'(ey))
            begin errors++; $display("FAIL %s y_vga px%0d got %0d want %0d", name, i, y_vga, 7'(ey)); end
         checks++;
         if (colour_vga !== exp_c)
            begin errors++; $display("FAIL %s colour_vga px%0d got %0d want %0d", name, i, colour_vga, exp_c); end
         if (writeEn === 1'b1) writes++;
      end
      plot = 1'b0; enable_posCounter = 1'b0; enable_waitCounter = 1'b0; sel_col = 1'b0;
      #1;
      checks++;
      if (done !== 1'b0)
         begin errors++; $display("FAIL %s done_idle got %b want 0", name, done); end
      tick();
      checks++;
      if (writeEn !== 1'b0)
         begin errors++; $display("FAIL %s writeEn_idle got %b want 0", name, writeEn); end
      checks++;
      if (writes !== exp_writes)
         begin errors++; $display("FAIL %s write_count got %0d want %0d", name, writes, exp_writes); end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      checks++;
      if ({x_vga, y_vga, colour_vga, writeEn} !== 19'd0)
         begin errors++; $display("FAIL reset outputs got x%0d y%0d c%0d we%b want 0", x_vga, y_vga, colour_vga, writeEn); end
      checks++;
      if ({done, waited} !== 2'b00)
         begin errors++; $display("FAIL reset status got done%b waited%b want 00", done, waited); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_draw();
      load(8'd10, 7'd20, 3'b100);
      sweep("draw", 8'd10, 7'd20, 3'b100, 1'b0, 1'b0, 16);
   endtask

   task automatic test_erase();
      sweep("erase", 8'd10, 7'd20, 3'b000, 1'b1, 1'b0, 16);
   endtask

   task automatic test_clip();
      load(8'd158, 7'd118, 3'b010);
      sweep("clip", 8'd158, 7'd118, 3'b010, 1'b0, 1'b0, 4);
   endtask

   task automatic test_wait();
      enable_waitCounter = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (waited !== 1'((i % 5) == 4))
            begin errors++; $display("FAIL wait cyc%0d got %b want %b", i, waited, ((i % 5) == 4)); end
         tick();
      end
      enable_waitCounter = 1'b0;
      tick();
      enable_waitCounter = 1'b1;
      tick(); tick(); tick();
      enable_waitCounter = 1'b0;
      #1;
      checks++;
      if (waited !== 1'b0)
         begin errors++; $display("FAIL wait_dropped got %b want 0", waited); end
      tick();
      enable_waitCounter = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (waited !== 1'(i == 4))
            begin errors++; $display("FAIL wait_restart cyc%0d got %b want %b", i, waited, (i == 4)); end
         tick();
      end
      enable_waitCounter = 1'b0;
      tick();
   endtask

   task automatic test_concurrent();
      load(8'd10, 7'd20, 3'b001);
      sweep("concurrent", 8'd10, 7'd20, 3'b001, 1'b0, 1'b1, 16);
   endtask

   task automatic test_reset_mid_sweep();
      load(8'd10, 7'd20, 3'b100);
      plot = 1'b1; enable_posCounter = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      resetn = 1'b0;
      tick();
      checks++;
      if (writeEn !== 1'b0)
         begin errors++; $display("FAIL midreset writeEn got %b want 0", writeEn); end
      checks++;
      if ({x_vga, y_vga, colour_vga} !== 18'd0)
         begin errors++; $display("FAIL midreset outputs got x%0d y%0d c%0d want 0", x_vga, y_vga, colour_vga); end
      checks++;
      if (done !== 1'b0)
         begin errors++; $display("FAIL midreset done got %b want 0", done); end
      resetn = 1'b1;
      sweep("after_reset", 8'd0, 7'd0, 3'b000, 1'b0, 1'b0, 16);
   endtask

   initial begin
      test_reset();
      test_draw();
      test_erase();
      test_clip();
      test_wait();
      test_concurrent();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
